// File: rtl/video_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// video_mem_responder_pkg
// Shared definitions for the screen-fetch SRAM responder: requester identity,
// SRAM address width, screen page numbers and the video-to-physical address
// mapping.
// ---------------------------------------------------------------------------
package video_mem_responder_pkg;

    typedef enum logic {
        OWNER_VIDEO = 1'b0,
        OWNER_CPU   = 1'b1
    } mem_owner_t;

    localparam int          SRAM_AW      = 19;
    localparam logic [4:0]  PAGE_SCREEN0 = 5'd5;
    localparam logic [4:0]  PAGE_SCREEN1 = 5'd7;

    // Screen memory lives in 16 KB page 5 or 7 of the 512 KB SRAM.
    function automatic logic [SRAM_AW-1:0] video_phys_addr(input logic        page,
                                                           input logic [13:0] offset);
        logic [2:0] page_sel;
        page_sel = page ? PAGE_SCREEN1[2:0] : PAGE_SCREEN0[2:0];
        return {2'b00, page_sel, offset};
    endfunction

endpackage

// File: rtl/video_mem_responder.sv
// ---------------------------------------------------------------------------
// video_mem_responder
// Arbitrates one external 8-bit SRAM between video screen fetches and CPU
// reads/writes. Each access takes two cycles (ACC1, ACC2); a new grant may be
// issued in ACC2 so the SRAM sustains one access every two cycles.
//
// Ports
//   clk28, rst                 28 MHz clock, async active-high reset
//   screen_page                selects screen page 5 (0) or 7 (1)
//   video_req/video_addr       video read request and 14-bit screen offset
//   video_ack                  pulse in the grant cycle
//   video_data_valid/_data     pulse one cycle after ACC2, byte held
//   cpu_req/cpu_wr/cpu_addr    CPU request, held until cpu_ack
//   cpu_wdata                  write byte, captured at grant
//   cpu_ack                    pulse in the grant cycle
//   cpu_rdata_valid/_rdata     read-only pulse one cycle after ACC2, byte held
//   sram_*                     SRAM pins; dq tristate merged by the parent
// ---------------------------------------------------------------------------
module video_mem_responder
    import video_mem_responder_pkg::*;
(
    input  logic               clk28,
    input  logic               rst,
    input  logic               screen_page,
    input  logic               video_req,
    input  logic [14:0]        video_addr,
    output logic               video_ack,
    output logic               video_data_valid,
    output logic [7:0]         video_data,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_rdata_valid,
    output logic [7:0]         cpu_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [7:0]         sram_dq_i,
    output logic [7:0]         sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    // state | meaning
    // IDLE  | no access in flight, SRAM strobes inactive
    // ACC1  | first access cycle (write strobe active for writes)
    // ACC2  | second access cycle, read data captured at its end
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC1 = 2'd1;
    localparam logic [1:0] ST_ACC2 = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    mem_owner_t         owner;
    mem_owner_t         last_owner;
    logic               acc_wr;
    logic [SRAM_AW-1:0] acc_addr;
    logic [7:0]         acc_wdata;

    logic               grant_slot;
    logic               grant_video;
    logic               grant_cpu;
    logic               access_active;

    // Only the 14-bit screen offset is meaningful.
    logic               video_addr_unused;
    assign video_addr_unused = video_addr[14];

    // Grants are gated by rst so no ack can appear while reset is held,
    // even though the requests feed the grant combinationally.
    always_comb begin
        grant_slot  = !rst && ((state == ST_IDLE) || (state == ST_ACC2));
        grant_video = grant_slot && video_req &&
                      (!cpu_req || (last_owner == OWNER_CPU));
        grant_cpu   = grant_slot && cpu_req && !grant_video;
    end

    assign video_ack = grant_video;
    assign cpu_ack   = grant_cpu;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_video || grant_cpu) state_next = ST_ACC1;
            ST_ACC1: state_next = ST_ACC2;
            ST_ACC2: state_next = (grant_video || grant_cpu) ? ST_ACC1 : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            owner            <= OWNER_CPU;
            last_owner       <= OWNER_CPU;
            acc_wr           <= 1'b0;
            acc_addr         <= '0;
            acc_wdata        <= '0;
            video_data_valid <= 1'b0;
            video_data       <= '0;
            cpu_rdata_valid  <= 1'b0;
            cpu_rdata        <= '0;
        end else begin
            state            <= state_next;
            video_data_valid <= 1'b0;
            cpu_rdata_valid  <= 1'b0;

            if (grant_video) begin
                owner      <= OWNER_VIDEO;
                last_owner <= OWNER_VIDEO;
                acc_wr     <= 1'b0;
                acc_addr   <= video_phys_addr(screen_page, video_addr[13:0]);
            end else if (grant_cpu) begin
                owner      <= OWNER_CPU;
                last_owner <= OWNER_CPU;
                acc_wr     <= cpu_wr;
                acc_addr   <= cpu_addr;
                acc_wdata  <= cpu_wdata;
            end

            // Read data is taken on the edge that ends ACC2; a grant in the
            // same cycle only overwrites the address/owner for the next access.
            if ((state == ST_ACC2) && !acc_wr) begin
                if (owner == OWNER_VIDEO) begin
                    video_data       <= sram_dq_i;
                    video_data_valid <= 1'b1;
                end else begin
                    cpu_rdata        <= sram_dq_i;
                    cpu_rdata_valid  <= 1'b1;
                end
            end
        end
    end

    // Pin strobes decode straight from the registered state, so an async
    // reset releases them in the same cycle.
    assign access_active = (state == ST_ACC1) || (state == ST_ACC2);
    assign sram_addr     = acc_addr;
    assign sram_dq_o     = acc_wdata;
    assign sram_dq_oe    = access_active && acc_wr;
    assign sram_oe_n     = !(access_active && !acc_wr);
    assign sram_we_n     = !((state == ST_ACC1) && acc_wr);

endmodule

// File: doc/video_mem_responder.md
# video_mem_responder

Memory-side responder for the video controller's screen-fetch port. It arbitrates a single external 8-bit SRAM between video read requests and CPU read/write requests, and maps the 15-bit video address onto the selected screen page. It returns acknowledge and data-valid strobes in the handshake the video controller expects. It sits between the video controller, the CPU bus glue and the SRAM pins, all on clk28.

## Interface
- No parameters; widths come from the shared package (SRAM_AW = 19).
- clk28  in  1  system clock, 28 MHz
- rst  in  1  asynchronous, active-high reset
- screen_page  in  1  0 = screen in page 5, 1 = screen in page 7
- video_req  in  1  video read request (may be held high permanently)
- video_addr  in  15  video address; bits [13:0] used
- video_ack  out  1  one-cycle pulse: video request accepted this cycle
- video_data_valid  out  1  one-cycle pulse: video_data holds the accepted byte
- video_data  out  8  last video read byte, held until the next video read
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  19  CPU physical SRAM address
- cpu_wdata  in  8  write data; sampled at grant
- cpu_ack  out  1  one-cycle pulse: CPU request accepted this cycle
- cpu_rdata_valid  out  1  one-cycle pulse, CPU reads only
- cpu_rdata  out  8  last CPU read byte, held
- sram_addr  out  19  SRAM address
- sram_dq_i  in  8  SRAM data in
- sram_dq_o  out  8  SRAM data out
- sram_dq_oe  out  1  drive enable for sram_dq_o
- sram_oe_n  out  1  SRAM output enable, active low
- sram_we_n  out  1  SRAM write enable, active low

## Operation
- Access FSM states:
  - IDLE → ACC1 on any grant.
  - ACC1 → ACC2 always.
  - ACC2 → ACC1 on a grant, otherwise IDLE.
- Grants occur only in IDLE or ACC2. A grant is combinational from the requests in that cycle, so ack is asserted in the same cycle as the grant.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: grant the owner opposite to last_owner.
  - last_owner updates on every grant; its reset value is CPU, so video wins the first tie.
- At grant, register owner, write flag, address and write data.
  - Video address = {2'b00, screen_page ? 3'd7 : 3'd5, video_addr[13:0]}.
  - screen_page is sampled at grant.
- Read access:
  - sram_addr is stable in ACC1 and ACC2.
  - sram_oe_n is low in ACC1 and ACC2.
  - sram_dq_i is registered on the clock edge ending ACC2, and the owner's valid pulse goes high the next cycle.
- Write access:
  - sram_addr and sram_dq_o are stable in ACC1 and ACC2, with sram_dq_oe high in both.
  - sram_we_n is low in ACC1 only.
  - sram_oe_n stays high.
  - Writes produce no valid pulse.
- sram_oe_n and sram_dq_oe are never both active.
- In IDLE: sram_oe_n = sram_we_n = 1 and sram_dq_oe = 0; sram_addr holds its last value.
- Reset values: all strobes 0; sram_oe_n and sram_we_n = 1; sram_dq_oe = 0; all address and data outputs 0; state IDLE; last_owner = CPU.
- Reset during any access aborts it immediately, asynchronously. No ack or valid follows for the aborted access.
- A request that drops before its ack is simply not served.

## Timing
- Grant or ack at cycle T, ACC1 at T+1, ACC2 at T+2, valid at T+3.
- Back-to-back grant possible at T+2, giving one access per 2 cycles.
- With both requesters continuous, grants alternate V, C, V, C… Each owner waits at most 2 cycles after its request before ack (worst case 4 cycles between its grants).
- Video alone with video_req held high: acks every 2 cycles, unthrottled.
- A CPU write granted at T is visible to a read granted at T+2 or later.

## Structure
- Add to the common package:
  - mem_owner_t enum {OWNER_VIDEO, OWNER_CPU}
  - localparams SRAM_AW = 19, PAGE_SCREEN0 = 5'd5, PAGE_SCREEN1 = 5'd7
- Single module; no sub-module. Tristate pin merging of sram_dq_o, sram_dq_i and sram_dq_oe happens at top level.

## Test plan
- Video only, video_req held high, screen_page = 0, video_addr = 15'h5800:
  - video_ack at T, T+2, T+4…; sram_addr = 19'h15800.
  - video_data_valid at T+3, T+5…, carrying the model byte at 19'h15800.
- screen_page = 1, video_addr = 15'h4000 → sram_addr = 19'h1C000. A toggle of screen_page mid-access does not change the in-flight address.
- CPU write 8'hA5 to 19'h12345, then CPU read of 19'h12345:
  - Write: sram_we_n low exactly 1 cycle; sram_dq_oe high 2 cycles; no cpu_rdata_valid.
  - Read: cpu_rdata = 8'hA5 at T+3.
- From reset, cpu_req and video_req rise in the same cycle, both held high:
  - First grant is video (video_ack), then cpu_ack 2 cycles later, continuing in alternation.
  - video_data_valid and cpu_rdata_valid never coincide.
- Assert rst during ACC1 of a CPU write:
  - Same cycle: sram_we_n = 1, sram_dq_oe = 0, all strobes 0.
  - After release with no requests: state IDLE, no ack or valid pulses.
- Protocol checker over a random mix of requests: sram_oe_n and sram_dq_oe are never both active. Every ack is followed by exactly one valid pulse for reads and none for writes.
